// File: rtl/uart_tx_top_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_top_pkg
// Description : Shared UART encodings for the transmitter: FSM states,
//               line levels, parity selectors and a parity helper.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_tx_top_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    localparam logic c_UART_IDLE   = 1'b1;
    localparam logic c_UART_START  = 1'b0;
    localparam logic c_UART_STOP   = 1'b1;
    localparam logic c_PARITY_EVEN = 1'b1;
    localparam logic c_PARITY_ODD  = 1'b0;

    // Caller passes the XOR-reduction of the payload so the helper is width-agnostic.
    function automatic logic calc_parity(input logic data_xor, input logic parity_type);
        return (parity_type == c_PARITY_EVEN) ? data_xor : ~data_xor;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_top_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_top_if
// Description : Parallel-in request handshake and serial-out line bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_top_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] p_data;
    logic                  data_valid;
    logic                  parity_en;
    logic                  parity_type;
    logic                  tx_out;
    logic                  busy;

    modport master (
        output p_data, data_valid, parity_en, parity_type,
        input  tx_out, busy
    );

    modport slave (
        input  p_data, data_valid, parity_en, parity_type,
        output tx_out, busy
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_bit_tick.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_bit_tick
// Description : Divides clk1 into serial bit periods; bit_done marks the last
//               cycle of each bit while run is high.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_bit_tick #(
    parameter int CLKS_PER_BIT = 1
) (
    input  wire logic clk1,
    input  wire logic rst,
    input  wire logic run,
    output logic      bit_done
);
    localparam int                  c_TICK_W    = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [c_TICK_W-1:0] c_LAST_TICK = c_TICK_W'(CLKS_PER_BIT - 1);

    logic [c_TICK_W-1:0] r_tick_cnt;

    // With one clock per bit the count never leaves zero, so the strobe follows run.
    assign bit_done = run && (r_tick_cnt == c_LAST_TICK);

    always_ff @(posedge clk1) begin
        if (!rst || !run || bit_done) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + c_TICK_W'(1);
        end
    end
endmodule
`default_nettype wire

// File: rtl/uart_tx_top.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_top
// Description : UART transmitter - start, LSB-first data, optional parity,
//               stop; registered glitch-free line output.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_top
    import uart_tx_top_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 1
) (
    input  wire logic     clk1,
    input  wire logic     rst,
    uart_tx_top_if.slave  tx_if
);
    localparam int                     c_BIT_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [c_BIT_CNT_W-1:0] c_LAST_BIT  = c_BIT_CNT_W'(DATA_WIDTH - 1);

    tx_state_t               r_state,   w_state_next;
    logic [DATA_WIDTH-1:0]   r_shift,   w_shift_next;
    logic [c_BIT_CNT_W-1:0]  r_bit_cnt, w_bit_cnt_next;
    logic                    r_par_en,  w_par_en_next;
    logic                    r_par,     w_par_next;
    logic                    r_tx,      w_tx_next;
    logic                    r_busy,    w_busy_next;
    logic                    w_run;
    logic                    w_bit_done;

    assign w_run = (r_state != ST_IDLE);

    uart_tx_bit_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_tick (
        .clk1     (clk1),
        .rst      (rst),
        .run      (w_run),
        .bit_done (w_bit_done)
    );

    always_ff @(posedge clk1) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_par_en  <= 1'b0;
            r_par     <= 1'b0;
            r_tx      <= c_UART_IDLE;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_shift   <= w_shift_next;
            r_bit_cnt <= w_bit_cnt_next;
            r_par_en  <= w_par_en_next;
            r_par     <= w_par_next;
            r_tx      <= w_tx_next;
            r_busy    <= w_busy_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_shift_next   = r_shift;
        w_bit_cnt_next = r_bit_cnt;
        w_par_en_next  = r_par_en;
        w_par_next     = r_par;

        case (r_state)
            ST_IDLE: begin
                // Frame settings are frozen here; later input changes are ignored.
                if (tx_if.data_valid) begin
                    w_state_next   = ST_START;
                    w_shift_next   = tx_if.p_data;
                    w_par_en_next  = tx_if.parity_en;
                    w_par_next     = calc_parity(^tx_if.p_data, tx_if.parity_type);
                    w_bit_cnt_next = '0;
                end
            end
            ST_START: begin
                if (w_bit_done) w_state_next = ST_DATA;
            end
            ST_DATA: begin
                if (w_bit_done) begin
                    if (r_bit_cnt == c_LAST_BIT) begin
                        w_state_next   = r_par_en ? ST_PARITY : ST_STOP;
                        w_bit_cnt_next = '0;
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + c_BIT_CNT_W'(1);
                        w_shift_next   = r_shift >> 1;
                    end
                end
            end
            ST_PARITY: begin
                if (w_bit_done) w_state_next = ST_STOP;
            end
            ST_STOP: begin
                if (w_bit_done) w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Line level is derived from the upcoming state so it registers alongside it.
    always_comb begin
        w_tx_next = c_UART_IDLE;
        case (w_state_next)
            ST_IDLE:   w_tx_next = c_UART_IDLE;
            ST_START:  w_tx_next = c_UART_START;
            ST_DATA:   w_tx_next = w_shift_next[0];
            ST_PARITY: w_tx_next = w_par_next;
            ST_STOP:   w_tx_next = c_UART_STOP;
            default:   w_tx_next = c_UART_IDLE;
        endcase
    end

    assign w_busy_next  = (w_state_next != ST_IDLE);
    assign tx_if.tx_out = r_tx;
    assign tx_if.busy   = r_busy;
endmodule
`default_nettype wire
